hazard_scoreboard: RTL and testbench

Parametrised successor to the per-instruction decode timing logic. It consumes the D-stage decode outputs (sources, Tuse, destination, Tnew) and keeps a shifting scoreboard of in-flight writers for stages 1..STAGES (E, M, W by default). From that scoreboard it generates the D-stage stall and the D-stage forwarding selects. It also tracks HI/LO busy time for the multi-cycle mult/div unit.

---
 rtl/hazard_scoreboard_pkg.sv | 28 ++
 rtl/hazard_scoreboard_md_busy_counter.sv | 31 +++
 rtl/hazard_scoreboard.sv | 108 ++++++++++
 tb/tb_hazard_scoreboard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and the scoreboard entry layout for the D-stage hazard logic.
// Also holds the saturating time-decrement helper.
package hazard_scoreboard_pkg;

    localparam int SB_REG_AW = 5;
    localparam int SB_TIME_W = 3;

    localparam logic [SB_TIME_W-1:0] TUSE_NONE = 3'd5;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [SB_REG_AW-1:0] dst;
        logic [SB_TIME_W-1:0] tnew;
    } sbEntry_t;

    // Tnew counts down one per stage and sticks at zero once the result exists
    function automatic logic [SB_TIME_W-1:0] decTime(input logic [SB_TIME_W-1:0] t);
        return (t == '0) ? '0 : t - 1'b1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Tracks how long the mult/div unit still owns HI/LO after an operation is accepted.
module md_busy_counter
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = $clog2(DIV_LAT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic isDiv,
    output logic busy
);

    logic [CNT_W-1:0] mdCnt;

    // A load restarts the count; otherwise it drains to zero and parks there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdCnt <= '0;
        end else if (load) begin
            mdCnt <= isDiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - 1'b1;
        end
    end

    assign busy = (mdCnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Shifting scoreboard of in-flight writers that produces the D-stage stall and
// forwarding selects, plus the HI/LO busy interlock for the mult/div unit.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int REG_AW   = SB_REG_AW,
    parameter int TIME_W   = SB_TIME_W,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int SEL_W    = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TIME_W-1:0] d_tuse_rs,
    input  logic [TIME_W-1:0] d_tuse_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TIME_W-1:0] d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_is_div,
    input  logic              d_md_use,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel_rs,
    output logic [SEL_W-1:0]  fwd_sel_rt,
    output logic              md_busy
);

    sbEntry_t entries [1:STAGES];

    logic [STAGES:1]   matchRs, matchRt;
    logic              hitRs, hitRt;
    logic [SEL_W-1:0]  selRs, selRt;
    logic [TIME_W-1:0] tnewRs, tnewRt;
    logic              dataStallRs, dataStallRt, mdStall, mdLoad;

    // Flush beats insertion; a stalled D inserts a bubble into stage 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) entries[k] <= '0;
        end else if (flush) begin
            for (int k = 1; k <= STAGES; k++) entries[k] <= '0;
        end else begin
            if (stall) begin
                entries[1] <= '0;
            end else begin
                entries[1] <= '{valid: d_valid && (d_dst != '0), dst: d_dst, tnew: decTime(d_tnew)};
            end
            for (int k = 2; k <= STAGES; k++) begin
                entries[k] <= '{valid: entries[k-1].valid, dst: entries[k-1].dst,
                                tnew: decTime(entries[k-1].tnew)};
            end
        end
    end

    for (genvar g = 1; g <= STAGES; g++) begin : gMatch
        assign matchRs[g] = entries[g].valid && (entries[g].dst == d_rs) && (d_rs != '0);
        assign matchRt[g] = entries[g].valid && (entries[g].dst == d_rt) && (d_rt != '0);
    end

    // Walk oldest to youngest so the lowest-numbered (youngest) match wins
    always_comb begin
        hitRs  = 1'b0;
        hitRt  = 1'b0;
        selRs  = '0;
        selRt  = '0;
        tnewRs = '0;
        tnewRt = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (matchRs[k]) begin
                hitRs  = 1'b1;
                selRs  = SEL_W'(k);
                tnewRs = entries[k].tnew;
            end
            if (matchRt[k]) begin
                hitRt  = 1'b1;
                selRt  = SEL_W'(k);
                tnewRt = entries[k].tnew;
            end
        end
    end

    assign dataStallRs = hitRs && (d_tuse_rs != TUSE_NONE) && (tnewRs > d_tuse_rs);
    assign dataStallRt = hitRt && (d_tuse_rt != TUSE_NONE) && (tnewRt > d_tuse_rt);
    assign mdStall     = d_md_use && md_busy;

    assign stall      = d_valid && !flush && (dataStallRs || dataStallRt || mdStall);
    assign fwd_sel_rs = (!flush && hitRs && tnewRs == '0) ? selRs : '0;
    assign fwd_sel_rt = (!flush && hitRt && tnewRt == '0) ? selRt : '0;

    // A start that is stalled or flushed never reaches the unit
    assign mdLoad = d_valid && d_md_start && !stall && !flush;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) uMdBusy (
        .clk   (clk),
        .reset (reset),
        .load  (mdLoad),
        .isDiv (d_md_is_div),
        .busy  (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed cycle-by-cycle vector table for hazard_scoreboard plus a reset-mid-div sequence.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush, d_valid;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [2:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_is_div, d_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_sel_rs, fwd_sel_rt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       flush, valid;
        logic [4:0] rs, rt, dst;
        logic [2:0] tuseRs, tuseRt, tnew;
        logic       mdStart, mdDiv, mdUse;
        logic       expStall;
        logic [1:0] expFwdRs, expFwdRt;
        logic       expBusy;
    } vec_t;

    vec_t vecs[$];

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .d_valid     (d_valid),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_dst       (d_dst),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_is_div (d_md_is_div),
        .d_md_use    (d_md_use),
        .stall       (stall),
        .fwd_sel_rs  (fwd_sel_rs),
        .fwd_sel_rt  (fwd_sel_rt),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    function automatic void add(string name, logic fl, logic v, int rs, int tRs, int rt, int tRt,
                                int dst, int tnew, logic ms, logic md, logic mu,
                                logic eS, int eFRs, int eFRt, logic eB);
        vec_t x;
        x.name = name;     x.flush = fl;         x.valid = v;
        x.rs = 5'(rs);     x.tuseRs = 3'(tRs);   x.rt = 5'(rt);   x.tuseRt = 3'(tRt);
        x.dst = 5'(dst);   x.tnew = 3'(tnew);
        x.mdStart = ms;    x.mdDiv = md;         x.mdUse = mu;
        x.expStall = eS;   x.expFwdRs = 2'(eFRs); x.expFwdRt = 2'(eFRt); x.expBusy = eB;
        vecs.push_back(x);
    endfunction

    function automatic void idle(int n);
        for (int i = 0; i < n; i++) add("idle", 0, 0, 0, N, 0, N, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        flush       = v.flush;
        d_valid     = v.valid;
        d_rs        = v.rs;
        d_rt        = v.rt;
        d_tuse_rs   = v.tuseRs;
        d_tuse_rt   = v.tuseRt;
        d_dst       = v.dst;
        d_tnew      = v.tnew;
        d_md_start  = v.mdStart;
        d_md_is_div = v.mdDiv;
        d_md_use    = v.mdUse;
    endtask

    initial begin
        // lw then dependent addu: one-cycle load-use stall
        add("A lw1",        0, 1, 0, 1, 0, N, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        add("A addu stall", 0, 1, 1, 1, 0, 1, 3, 2, 0, 0, 0, 1, 0, 0, 0);
        add("A addu go",    0, 1, 1, 1, 0, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // lw then beq reading it at D: two stalls then forward from W
        add("B lw1",        0, 1, 0, 1, 0, N, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        add("B beq s1",     0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add("B beq s2",     0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add("B beq fwd",    0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0);
        idle(3);
        // youngest writer wins over an older ready one
        add("C lw5",        0, 1, 0, 1, 0, N, 5, 3, 0, 0, 0, 0, 0, 0, 0);
        add("C ori5",       0, 1, 0, 1, 0, N, 5, 2, 0, 0, 0, 0, 0, 0, 0);
        add("C jr stall",   0, 1, 5, 0, 0, N, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add("C jr fwd",     0, 1, 5, 0, 0, N, 0, 0, 0, 0, 0, 0, 2, 0, 0);
        idle(3);
        // $0 writes and reads
        add("D lui0",       0, 1, 0, 1, 0, N, 0, 2, 0, 0, 0, 0, 0, 0, 0);
        add("D addu00",     0, 1, 0, 1, 0, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Tuse NONE never stalls even against a large Tnew
        add("E big tnew",   0, 1, 0, 1, 0, N, 7, 7, 0, 0, 0, 0, 0, 0, 0);
        add("E tuse none",  0, 1, 7, N, 7, N, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // mult then mflo waits five cycles
        add("F mult",       0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add("F mflo wait", 0, 1, 0, N, 0, N, 8, 2, 0, 0, 1, 1, 0, 0, 1);
        add("F mflo go",    0, 1, 0, N, 0, N, 8, 2, 0, 0, 1, 0, 0, 0, 0);
        idle(3);
        // div, a second mult while busy is stalled (no restart), mflo after ten
        add("G div",        0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        add("G mult busy",  0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 9; i++) add("G mflo wait", 0, 1, 0, N, 0, N, 8, 2, 0, 0, 1, 1, 0, 0, 1);
        add("G mflo go",    0, 1, 0, N, 0, N, 8, 2, 0, 0, 1, 0, 0, 0, 0);
        idle(3);
        // flush kills the lw and masks the stall
        add("H lw2",        0, 1, 0, 1, 0, N, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        add("H jr stall",   0, 1, 2, 0, 0, N, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add("H jr flush",   1, 1, 2, 0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("H jr after",   0, 1, 2, 0, 0, N, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // flush forces forwarding selects to zero
        add("K lw2",        0, 1, 0, 1, 0, N, 2, 3, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        add("K flush fwd",  1, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("K after",      0, 1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // flush together with md start drops the start
        add("M flush mult", 1, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        idle(1);

        applyStimulus('{name: "init", flush: 0, valid: 0, rs: 0, rt: 0, dst: 0, tuseRs: 5, tuseRt: 5,
                        tnew: 0, mdStart: 0, mdDiv: 0, mdUse: 0, expStall: 0, expFwdRs: 0,
                        expFwdRt: 0, expBusy: 0});
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset stall",  {7'd0, stall},  8'd0);
        checkOutput("reset fwdRs",  {6'd0, fwd_sel_rs}, 8'd0);
        checkOutput("reset fwdRt",  {6'd0, fwd_sel_rt}, 8'd0);
        checkOutput("reset busy",   {7'd0, md_busy}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, " stall"}, {7'd0, stall}, {7'd0, vecs[i].expStall});
            checkOutput({vecs[i].name, " fwdRs"}, {6'd0, fwd_sel_rs}, {6'd0, vecs[i].expFwdRs});
            checkOutput({vecs[i].name, " fwdRt"}, {6'd0, fwd_sel_rt}, {6'd0, vecs[i].expFwdRt});
            checkOutput({vecs[i].name, " busy"}, {7'd0, md_busy}, {7'd0, vecs[i].expBusy});
        end

        // reset asserted mid-div clears busy and stall without waiting for a clock
        @(negedge clk);
        applyStimulus('{name: "R div", flush: 0, valid: 1, rs: 0, rt: 0, dst: 0, tuseRs: 1, tuseRt: 1,
                        tnew: 0, mdStart: 1, mdDiv: 1, mdUse: 1, expStall: 0, expFwdRs: 0,
                        expFwdRt: 0, expBusy: 0});
        @(negedge clk);
        applyStimulus('{name: "R mflo", flush: 0, valid: 1, rs: 0, rt: 0, dst: 8, tuseRs: 5, tuseRt: 5,
                        tnew: 2, mdStart: 0, mdDiv: 0, mdUse: 1, expStall: 1, expFwdRs: 0,
                        expFwdRt: 0, expBusy: 1});
        #1;
        checkOutput("R pre stall", {7'd0, stall},  8'd1);
        checkOutput("R pre busy",  {7'd0, md_busy}, 8'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("R async stall", {7'd0, stall},  8'd0);
        checkOutput("R async busy",  {7'd0, md_busy}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("R after stall", {7'd0, stall},  8'd0);
        checkOutput("R after busy",  {7'd0, md_busy}, 8'd0);
        d_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
